// File: rtl/mul16_sequencer_pkg.sv
// Shared definitions for the 16x16 multiply sequencer.
// - state_t     : FSM state encoding (IDLE=0, STEP=1, DONE=2)
// - shift_sel_t : accumulator shift select for the four 8x8 sub-products
// - step_shift  : maps step index k to its shift (0/8/8/16)
package mul16_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_0  = 2'd0,
    SH_8  = 2'd1,
    SH_16 = 2'd2
  } shift_sel_t;

  localparam logic [1:0] STEP_LAST = 2'd3;

  // k=0: lo*lo (<<0), k=1/2: cross terms (<<8), k=3: hi*hi (<<16)
  function automatic shift_sel_t step_shift(input logic [1:0] k);
    case (k)
      2'd0:    step_shift = SH_0;
      2'd1:    step_shift = SH_8;
      2'd2:    step_shift = SH_8;
      default: step_shift = SH_16;
    endcase
  endfunction

endpackage

// File: rtl/mul_accum_32.sv
// 32-bit accumulator with synchronous clear and shifted add of a 16-bit term.
// Ports:
//   clk, reset : clock, synchronous active-high reset (acc -> 0)
//   clear      : load zero (takes priority over add_en)
//   add_en     : acc <= acc + ({16'b0, add_in} << shift)
//   add_in     : 16-bit sub-product
//   shift_sel  : shift select (0, 8 or 16)
//   acc        : registered accumulator value
module mul_accum_32
  import mul16_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_en,
  input  logic [15:0] add_in,
  input  shift_sel_t  shift_sel,
  output logic [31:0] acc
);

  logic [31:0] term;

  always_comb begin
    term = 32'd0;
    case (shift_sel)
      SH_0:    term = {16'd0, add_in};
      SH_8:    term = {8'd0, add_in, 8'd0};
      SH_16:   term = {add_in, 16'd0};
      default: term = 32'd0;
    endcase
  end

  // The full product never exceeds 0xFFFE0001, so no carry-out is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= 32'd0;
    end else if (clear) begin
      acc <= 32'd0;
    end else if (add_en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/mul16_sequencer.sv
// Unsigned 16x16 -> 32 multiply by time-sharing one external 8x8 core.
// Four sub-products are issued in order (lo*lo, lo*hi, hi*lo, hi*hi) and
// accumulated with shifts 0/8/8/16.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; out_valid/out_p hold steady until out_ready; mul_* advances only on
// edges where mul_req & mul_gnt.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only in IDLE)
//   in_a, in_b            : 16-bit unsigned operands
//   out_valid/out_ready   : result handshake
//   out_p                 : 32-bit product (keeps last value in IDLE)
//   mul_req/mul_gnt       : request/grant to the shared 8x8 core
//   mul_a, mul_b, mul_p   : core operands (0 outside STEP) and its product
module mul16_sequencer
  import mul16_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        mul_req,
  input  logic        mul_gnt,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  state_t      state;
  logic [1:0]  k;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        accept;
  logic        step_fire;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign step_fire = (state == ST_STEP) && mul_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      k     <= 2'd0;
      a_q   <= 16'd0;
      b_q   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            k     <= 2'd0;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (mul_gnt) begin
            k <= k + 2'd1;
            if (k == STEP_LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registered state only: no path from mul_gnt to mul_req/mul_a/mul_b.
  always_comb begin
    mul_a = 8'd0;
    mul_b = 8'd0;
    if (state == ST_STEP) begin
      case (k)
        2'd0:    begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  end
        2'd1:    begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
        2'd2:    begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  end
        default: begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
      endcase
    end
  end

  assign mul_req   = (state == ST_STEP);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  mul_accum_32 u_accum (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .add_en    (step_fire),
    .add_in    (mul_p),
    .shift_sel (step_shift(k)),
    .acc       (out_p)
  );

endmodule

// File: tb/tb_mul16_sequencer.sv
// Directed and randomized bench for mul16_sequencer with a behavioural 8x8 core.
module tb_mul16_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        mul_req;
  logic        mul_gnt;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  got_b[$];
  bit          chk_stall = 1'b0;
  bit          poke = 1'b0;

  // clock/reset
  always #5 clk = ~clk;

  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  mul16_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .mul_req   (mul_req),
    .mul_gnt   (mul_gnt),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present operands in a cycle where the block must be idle; accepted on the next edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    check("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({16'd0, a} * {16'd0, b});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // gnt_pat bit n-1 is the grant in cycle n after accept; hold = DONE cycles with out_ready low.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] gnt_pat, input int hold);
    int grants;
    int exp_lat;
    int lat;
    logic [31:0] exp_p;
    logic [31:0] held_p;
    grants  = 0;
    exp_lat = 0;
    lat     = 0;
    got_b.delete();
    out_ready = (hold == 0);
    accept(a, b);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      mul_gnt = (n <= 32) ? gnt_pat[n-1] : 1'b1;
      if (chk_stall && n >= 2 && n <= 4) begin
        check("stall_req", {31'd0, mul_req}, 32'd1);
        check("stall_mul_a", {24'd0, mul_a}, {24'd0, a[7:0]});
        check("stall_mul_b", {24'd0, mul_b}, {24'd0, b[15:8]});
      end
      if (mul_gnt && mul_req) got_b.push_back(mul_b);
      if (mul_gnt) grants++;
      if (grants == 4 && exp_lat == 0) exp_lat = n + 1;
    end
    mul_gnt = 1'b1;
    check("latency", lat, exp_lat);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("out_p", out_p, exp_p);
    held_p = out_p;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
      end
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_p", out_p, held_p);
      if (poke) begin
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_mul_a", {24'd0, mul_a}, 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'd0;
    in_b      = 16'd0;
    out_ready = 1'b0;
    mul_gnt   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_p", out_p, 32'd0);
    check("rst_mul_req", {31'd0, mul_req}, 32'd0);
    check("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);

    // Basic product, full grant, also checks operand sequencing.
    run_op(16'h1234, 16'h5678, 32'hFFFF_FFFF, 0);
    check("seq_len", got_b.size(), 4);
    if (got_b.size() == 4) begin
      check("seq_b0", {24'd0, got_b[0]}, 32'h78);
      check("seq_b1", {24'd0, got_b[1]}, 32'h56);
      check("seq_b2", {24'd0, got_b[2]}, 32'h78);
      check("seq_b3", {24'd0, got_b[3]}, 32'h56);
    end
    check("p_1234x5678", out_p, 32'h0626_0060);
    // out_p keeps its value in IDLE
    @(negedge clk);
    check("idle_keep_p", out_p, 32'h0626_0060);

    run_op(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 0);
    check("p_max", out_p, 32'hFFFE_0001);
    run_op(16'h0000, 16'hABCD, 32'hFFFF_FFFF, 0);
    check("p_zero", out_p, 32'h0000_0000);
    run_op(16'h0100, 16'h0100, 32'hFFFF_FFFF, 0);
    check("p_0100sq", out_p, 32'h0001_0000);

    // Grant low for three cycles at k=1: result at accept+8.
    chk_stall = 1'b1;
    run_op(16'h1234, 16'h5678, 32'hFFFF_FFF1, 0);
    chk_stall = 1'b0;
    check("p_stall", out_p, 32'h0626_0060);

    // out_ready low 4 cycles in DONE with a stray in_valid; next op is accepted next cycle.
    poke = 1'b1;
    run_op(16'h0002, 16'h0003, 32'hFFFF_FFFF, 4);
    poke = 1'b0;
    run_op(16'h0007, 16'h0009, 32'hFFFF_FFFF, 0);
    check("p_after_hold", out_p, 32'h0000_003F);

    // Reset during k=2.
    out_ready = 1'b1;
    accept(16'h1234, 16'h5678);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'd0, mul_req}, 32'd1);
    check("pre_rst_mul_a", {24'd0, mul_a}, 32'h12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_mul_req", {31'd0, mul_req}, 32'd0);
    check("mid_rst_out_p", out_p, 32'd0);
    run_op(16'h0003, 16'h0005, 32'hFFFF_FFFF, 0);
    check("p_after_rst", out_p, 32'h0000_000F);

    // Randomized operands with grant and out_ready stalls.
    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
             $urandom() | $urandom(), $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
